// File: rtl/wide2narrow_ser.sv
// Wide-to-narrow serializer: one IN_W-bit input word becomes up to IN_W/OUT_W OUT_W-bit words.
// A one-entry pending buffer behind the active shift register keeps the output stream gapless.
module wide2narrow_ser #(
    parameter int unsigned IN_W      = 256,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned RATIO    = IN_W / OUT_W,
    localparam int unsigned CNT_W    = $clog2(RATIO + 1)
) (
    input  logic             sclk,
    input  logic             srst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [CNT_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam logic [CNT_W-1:0] RatioCnt = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] OneCnt   = CNT_W'(1);

    // State mirrors occupancy: active only, or active plus pending.
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [IN_W-1:0]    r_act_data;
    logic [IN_W-1:0]    w_act_data_d;
    logic [CNT_W-1:0]   r_act_cnt;
    logic [CNT_W-1:0]   w_act_cnt_d;
    logic [IN_W-1:0]    r_pend_data;
    logic [IN_W-1:0]    w_pend_data_d;
    logic [CNT_W-1:0]   r_pend_len;
    logic [CNT_W-1:0]   w_pend_len_d;

    logic               w_act_full;
    logic               w_pend_full;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_last;
    logic               w_drain;
    logic [CNT_W-1:0]   w_len_eff;
    logic [IN_W-1:0]    w_act_shift;
    logic [OUT_W-1:0]   w_head;

    assign w_act_full  = (r_state != StEmpty);
    assign w_pend_full = (r_state == StTwo);

    assign in_ready  = srst_n & ~w_pend_full;
    assign out_valid = w_act_full;
    assign busy      = w_act_full | w_pend_full;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = w_act_full & out_ready;
    assign w_last     = w_act_full & (r_act_cnt == OneCnt);
    assign w_drain    = w_out_xfer & w_last;

    // Zero and oversized lengths both mean "the whole word".
    assign w_len_eff = ((in_len == '0) || (in_len > RatioCnt)) ? RatioCnt : in_len;

    assign w_act_shift = MSB_FIRST ? (r_act_data << OUT_W) : (r_act_data >> OUT_W);
    assign w_head      = MSB_FIRST ? r_act_data[IN_W-1 -: OUT_W] : r_act_data[OUT_W-1:0];

    assign out_data = w_act_full ? w_head : '0;
    assign out_last = w_last;

    always_comb begin
        w_state_d     = r_state;
        w_act_data_d  = r_act_data;
        w_act_cnt_d   = r_act_cnt;
        w_pend_data_d = r_pend_data;
        w_pend_len_d  = r_pend_len;
        unique case (r_state)
            StEmpty: begin
                if (w_in_xfer) begin
                    w_act_data_d = in_data;
                    w_act_cnt_d  = w_len_eff;
                    w_state_d    = StOne;
                end
            end
            StOne: begin
                if (w_drain) begin
                    // An input arriving on the drain edge becomes active directly.
                    if (w_in_xfer) begin
                        w_act_data_d = in_data;
                        w_act_cnt_d  = w_len_eff;
                    end else begin
                        w_act_cnt_d = '0;
                        w_state_d   = StEmpty;
                    end
                end else begin
                    if (w_out_xfer) begin
                        w_act_data_d = w_act_shift;
                        w_act_cnt_d  = r_act_cnt - OneCnt;
                    end
                    if (w_in_xfer) begin
                        w_pend_data_d = in_data;
                        w_pend_len_d  = w_len_eff;
                        w_state_d     = StTwo;
                    end
                end
            end
            StTwo: begin
                if (w_drain) begin
                    w_act_data_d = r_pend_data;
                    w_act_cnt_d  = r_pend_len;
                    w_state_d    = StOne;
                end else if (w_out_xfer) begin
                    w_act_data_d = w_act_shift;
                    w_act_cnt_d  = r_act_cnt - OneCnt;
                end
            end
            default: begin
                w_act_cnt_d = '0;
                w_state_d   = StEmpty;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_state     <= StEmpty;
            r_act_data  <= '0;
            r_act_cnt   <= '0;
            r_pend_data <= '0;
            r_pend_len  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_act_data  <= w_act_data_d;
            r_act_cnt   <= w_act_cnt_d;
            r_pend_data <= w_pend_data_d;
            r_pend_len  <= w_pend_len_d;
        end
    end

endmodule

// File: tb/tb_wide2narrow_ser.sv
// Directed bench for wide2narrow_ser: one 256-bit MSB-first instance and two 32-bit instances
// (LSB-first and MSB-first); inputs change and outputs are checked on the falling edge.
module tb_wide2narrow_ser;

    localparam int unsigned CW_A = 6;  // clog2(32+1)
    localparam int unsigned CW_B = 3;  // clog2(4+1)

    logic clk = 1'b0;
    logic srst_n;
    always #5 clk = ~clk;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
    logic [255:0]    a_in_data;
    logic [CW_A-1:0] a_in_len;
    logic [7:0]      a_out_data;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [31:0]     b_in_data;
    logic [CW_B-1:0] b_in_len;
    logic [7:0]      b_out_data;

    logic            c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_busy;
    logic [31:0]     c_in_data;
    logic [CW_B-1:0] c_in_len;
    logic [7:0]      c_out_data;

    wide2narrow_ser #(.IN_W(256), .OUT_W(8), .MSB_FIRST(1'b1)) u_a (
        .sclk(clk), .srst_n(srst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_len(a_in_len), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
    );
    wide2narrow_ser #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_b (
        .sclk(clk), .srst_n(srst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_len(b_in_len), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
    );
    wide2narrow_ser #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_c (
        .sclk(clk), .srst_n(srst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_len(c_in_len), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last), .busy(c_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [47:0] seq3;
    logic [31:0] w4;
    int          idx;

    initial begin
        srst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_in_len = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_len = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_data = '0; c_in_len = '0; c_out_ready = 1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_last", a_out_last, 0);
        srst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", a_in_ready, 1);
        chk("idle_out_valid", a_out_valid, 0);

        // Full 256-bit word, MSB first, bytes 00..1F
        for (int i = 0; i < 32; i++) a_in_data[255-8*i -: 8] = 8'(i);
        a_in_len = '0;
        a_in_valid = 1;
        @(negedge clk);
        a_in_valid = 0;
        for (int i = 0; i < 32; i++) begin
            chk("t1_valid", a_out_valid, 1);
            chk("t1_data", a_out_data, 8'(i));
            chk("t1_last", a_out_last, (i == 31));
            @(negedge clk);
        end
        chk("t1_end_valid", a_out_valid, 0);
        chk("t1_end_busy", a_busy, 0);

        // Back-to-back LSB-first inputs; second waits in pending
        b_in_data = 32'hA3A2A1A0; b_in_valid = 1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("t2_valid", b_out_valid, 1);
            chk("t2_data", b_out_data, (k < 4) ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k - 4));
            chk("t2_last", b_out_last, (k == 3) || (k == 7));
            chk("t2_in_ready", b_in_ready, (k == 0) || (k >= 4));
            if (k == 0) b_in_data = 32'hB3B2B1B0;
            if (k == 1) b_in_valid = 0;
            @(negedge clk);
        end
        chk("t2_end_valid", b_out_valid, 0);

        // Length 2, then length 7 clamped to 4
        seq3 = 48'h112211223344;
        c_in_data = 32'h11223344; c_in_len = 3'd2; c_in_valid = 1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk("t3_valid", c_out_valid, 1);
            chk("t3_data", c_out_data, seq3[47-8*k -: 8]);
            chk("t3_last", c_out_last, (k == 1) || (k == 5));
            if (k == 0) c_in_len = 3'd7;
            if (k == 1) begin
                chk("t3_in_ready", c_in_ready, 0);
                c_in_valid = 0;
            end
            @(negedge clk);
        end
        chk("t3_end_valid", c_out_valid, 0);

        // Output stalls: ready pattern 1,0,0,1,...
        w4 = 32'hDEADBEEF;
        c_in_data = w4; c_in_len = '0; c_in_valid = 1;
        @(negedge clk);
        c_in_valid = 0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            c_out_ready = (c % 3 == 0);
            chk("t4_valid", c_out_valid, 1);
            chk("t4_data", c_out_data, w4[31-8*idx -: 8]);
            chk("t4_last", c_out_last, (idx == 3));
            if (c_out_ready) idx++;
            @(negedge clk);
        end
        c_out_ready = 1;
        chk("t4_end_valid", c_out_valid, 0);

        // Asynchronous reset mid-stream with pending full
        b_in_data = 32'hA3A2A1A0; b_in_valid = 1;
        @(negedge clk);
        chk("t5_a0", b_out_data, 8'hA0);
        b_in_data = 32'hB3B2B1B0;
        @(negedge clk);
        chk("t5_a1", b_out_data, 8'hA1);
        chk("t5_pend_in_ready", b_in_ready, 0);
        b_in_valid = 0;
        @(negedge clk);
        chk("t5_a2", b_out_data, 8'hA2);
        chk("t5_busy_pre", b_busy, 1);
        #2 srst_n = 1'b0;
        #1;
        chk("t5_rst_valid", b_out_valid, 0);
        chk("t5_rst_busy", b_busy, 0);
        chk("t5_rst_last", b_out_last, 0);
        chk("t5_rst_data", b_out_data, 0);
        chk("t5_rst_in_ready", b_in_ready, 0);
        @(negedge clk);
        srst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_quiet_valid", b_out_valid, 0);
        end
        b_in_data = 32'hC3C2C1C0; b_in_valid = 1;
        @(negedge clk);
        b_in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_new_data", b_out_data, 8'hC0 + 8'(k));
            chk("t5_new_last", b_out_last, (k == 3));
            @(negedge clk);
        end
        chk("t5_end_valid", b_out_valid, 0);

        // in_valid held high with changing data while pending is full
        c_in_data = 32'h01020304; c_in_len = '0; c_in_valid = 1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            chk("t6_valid", c_out_valid, 1);
            chk("t6_data", c_out_data, 8'(k + 1));
            chk("t6_last", c_out_last, (k % 4 == 3));
            chk("t6_in_ready", c_in_ready, (k == 0) || (k == 4) || (k >= 8));
            case (k)
                0: c_in_data = 32'h05060708;
                1: c_in_data = 32'hAAAAAAAA;
                2: c_in_data = 32'hBBBBBBBB;
                3: c_in_data = 32'h090A0B0C;
                4: c_in_data = 32'h090A0B0C;
                default: c_in_valid = 0;
            endcase
            @(negedge clk);
        end
        chk("t6_end_valid", c_out_valid, 0);
        chk("t6_end_busy", c_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wide2narrow_ser.md
# wide2narrow_ser

Parametrised wide-to-narrow serializer with valid/ready handshaking on both sides. It accepts one IN_W-bit word and emits it as up to IN_W/OUT_W consecutive OUT_W-bit words, flagging the final word of each input. Word order and per-input length are selectable. It sits between wide frame/pixel buffers (e.g. 256-bit RAM read ports) and byte-wide sinks such as the UART/HDMI pixel path. A one-entry pending buffer lets a new input be accepted while the current one drains, so output runs back-to-back without bubbles.

## Interface
- IN_W, 256, input word width; must be an integer multiple of OUT_W, with IN_W/OUT_W ≥ 2.
- OUT_W, 8, output word width.
- MSB_FIRST, 1: 1 emits in_data[IN_W-1 -: OUT_W] first; 0 emits in_data[OUT_W-1:0] first.
- Derived: RATIO = IN_W/OUT_W; CNT_W = clog2(RATIO+1).

- sclk  in  1  system clock; all state changes on the rising edge.
- srst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data/in_len valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  IN_W  wide word.
- in_len  in  CNT_W  number of output words to emit from this input; 0 or >RATIO means RATIO.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data this cycle.
- out_data  out  OUT_W  narrow word.
- out_last  out  1  out_data is the final word of its input.
- busy  out  1  = out_valid | pending entry full.

## Operation
- Storage: an active shift register with its remaining-word counter, plus one pending entry (data and effective length).
- States, encoded by occupancy:
  - EMPTY: no active, no pending.
  - ONE: active only.
  - TWO: active and pending.
- Input transfer occurs when in_valid & in_ready.
  - in_ready = srst_n & ~pending_full (combinational). It is 1 in EMPTY and ONE, 0 in TWO.
- Output transfer occurs when out_valid & out_ready. out_valid = active occupied.
- On an output transfer of a non-final word:
  - the active register shifts by OUT_W toward the emit end;
  - the counter decrements;
  - out_last = (counter == 1).
- On an output transfer of the final word (the "drain"), the next active content is, in priority order:
  - the pending entry, if full (pending becomes empty);
  - otherwise the input transferred this cycle;
  - otherwise none (go to EMPTY).
- If an input transfers in the same cycle that pending moves to active, the input goes into pending (TWO stays TWO; in_ready was 0, so this only arises from ONE, which becomes ONE with a new active).
- An input transferring with no drain goes to active if active is empty, otherwise to pending.
- Effective length is clamped once at input transfer time and stored.
- in_data/in_len are sampled only on an input transfer. Changing them while in_ready=0 has no effect.
- out_data and out_last are held stable while out_valid & ~out_ready (AXI-style hold).
- Reset (asynchronous, any time, mid-word included):
  - the active and pending entries are discarded and the state goes to EMPTY;
  - out_valid=0, out_last=0, out_data=0, busy=0;
  - in_ready=0 while srst_n=0.
  - After reset release, no output appears until a new input transfers.

## Timing
- Latency: an input transferred at edge N into an empty block shows out_valid=1 with the first word right after edge N.
- Throughput:
  - With out_ready held 1, inputs of length L produce L words in L consecutive cycles each.
  - The next input's first word follows the previous last word with zero bubble cycles, provided it transferred before the drain edge.
- out_valid never drops between the words of one input.
- out_last is high for exactly one output transfer per input.
- Length 1 input: a single word is emitted with out_last=1.
- Sustained rate: a new input can be accepted at most once per L cycles at steady state. in_ready rises in the cycle after pending moves to active.
- Simultaneous drain and input transfer are handled as specified in Operation; no input is ever lost or duplicated.

## Test plan
- IN_W=256, OUT_W=8, MSB_FIRST=1, in_len=0, in_data=256'h00_01_…_1F, out_ready=1 → 32 consecutive words 8'h00…8'h1F, out_last only on 8'h1F, first word one cycle after acceptance.
- IN_W=32, MSB_FIRST=0, two back-to-back inputs 32'hA3A2A1A0 and 32'hB3B2B1B0, out_ready=1 → A0,A1,A2,A3,B0,B1,B2,B3 with no gap; out_last on A3 and B3; in_ready=0 while pending full.
- IN_W=32, in_len=2 then in_len=7 on 32'h11223344 (MSB_FIRST=1) → 11,22 (last on 22), then 11,22,33,44 (clamped to 4, last on 44).
- out_ready toggled 1,0,0,1,… during a 32-bit input → out_data/out_last stable across stall cycles, no word skipped, total 4 transfers.
- srst_n pulsed low asynchronously after 2 of 4 words with pending full → out_valid, busy, out_last go to 0 immediately; after release, no output until new input; the next input emits its own 4 words only.
- in_valid held 1 with changing data while in state TWO → only values present at in_ready=1 edges appear at the output.
